// File: rtl/mac_operand_feeder.sv
// Operand feeder for the mac datapath: buffers A/B vectors, streams them PARALLEL lanes per beat,
// then captures the mac result on a done rising edge or flags a timeout.
module mac_operand_feeder #(
   parameter int PARALLEL = 1,
   parameter int DEPTH    = 25,
   parameter int DW       = 8,
   parameter int AW       = 5,
   parameter int TIMEOUT  = 500
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DW-1:0]          wr_data,
   input  logic                   go,
   output logic                   busy,
   output logic                   mac_start,
   output logic [PARALLEL*DW-1:0] din_a,
   output logic [PARALLEL*DW-1:0] din_b,
   input  logic                   mac_done,
   input  logic [15:0]            mac_dout,
   output logic [15:0]            result,
   output logic                   result_valid,
   output logic                   timeout_err
);

   localparam int NBEATS = (DEPTH + PARALLEL - 1) / PARALLEL;
   localparam int BW     = $clog2(NBEATS + 1);
   localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    start_q, start_d;
   logic [PARALLEL*DW-1:0]  din_a_q, din_a_d;
   logic [PARALLEL*DW-1:0]  din_b_q, din_b_d;
   logic [15:0]             result_q, result_d;
   logic                    rvalid_q, rvalid_d;
   logic                    terr_q, terr_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    done_prev_q, done_prev_d;

   logic [DW-1:0]           mem_a_q [2**AW];
   logic [DW-1:0]           mem_b_q [2**AW];

   logic                    wr_accept;
   logic                    done_rise;
   logic [PARALLEL*DW-1:0]  beat_a, beat_b;
   int                      lane_idx;

   assign wr_accept = wr_en && !busy_q && (int'(wr_addr) < DEPTH);
   assign done_rise = mac_done && !done_prev_q;

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         if (wr_sel) mem_b_q[wr_addr] <= wr_data;
         else        mem_a_q[wr_addr] <= wr_data;
      end
   end

   // beat_q is held at 0 whenever the FSM is idle, so this mux also yields beat 0 for the go edge
   always_comb begin
      beat_a   = '0;
      beat_b   = '0;
      lane_idx = 0;
      for (int unsigned j = 0; j < PARALLEL; j++) begin
         lane_idx = int'(beat_q) * PARALLEL + int'(j);
         if (lane_idx < DEPTH) begin
            beat_a[j*DW +: DW] = mem_a_q[lane_idx[AW-1:0]];
            beat_b[j*DW +: DW] = mem_b_q[lane_idx[AW-1:0]];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      start_d     = start_q;
      din_a_d     = din_a_q;
      din_b_d     = din_b_q;
      result_d    = result_q;
      rvalid_d    = 1'b0;
      terr_d      = terr_q;
      beat_d      = beat_q;
      cnt_d       = cnt_q;
      done_prev_d = mac_done;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_STREAM;
               busy_d  = 1'b1;
               start_d = 1'b1;
               din_a_d = beat_a;
               din_b_d = beat_b;
               beat_d  = BW'(1);
               terr_d  = 1'b0;
            end
         end
         S_STREAM: begin
            // a done rise on the final-beat edge takes priority over entering WAIT
            if (done_rise) begin
               state_d  = S_DONE;
               result_d = mac_dout;
               rvalid_d = 1'b1;
               start_d  = 1'b0;
               din_a_d  = '0;
               din_b_d  = '0;
               beat_d   = '0;
            end else if (beat_q == BW'(NBEATS)) begin
               state_d = S_WAIT;
               din_a_d = '0;
               din_b_d = '0;
               beat_d  = '0;
               cnt_d   = '0;
            end else begin
               din_a_d = beat_a;
               din_b_d = beat_b;
               beat_d  = beat_q + BW'(1);
            end
         end
         S_WAIT: begin
            if (done_rise) begin
               state_d  = S_DONE;
               result_d = mac_dout;
               rvalid_d = 1'b1;
               start_d  = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               terr_d  = 1'b1;
               start_d = 1'b0;
               busy_d  = 1'b0;
               din_a_d = '0;
               din_b_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         din_a_q     <= '0;
         din_b_q     <= '0;
         result_q    <= '0;
         rvalid_q    <= 1'b0;
         terr_q      <= 1'b0;
         beat_q      <= '0;
         cnt_q       <= '0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         din_a_q     <= din_a_d;
         din_b_q     <= din_b_d;
         result_q    <= result_d;
         rvalid_q    <= rvalid_d;
         terr_q      <= terr_d;
         beat_q      <= beat_d;
         cnt_q       <= cnt_d;
         done_prev_q <= done_prev_d;
      end
   end

   assign busy         = busy_q;
   assign mac_start    = start_q;
   assign din_a        = din_a_q;
   assign din_b        = din_b_q;
   assign result       = result_q;
   assign result_valid = rvalid_q;
   assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench: one feeder with PARALLEL=1 and one with PARALLEL=4 sharing the write/go inputs,
// each driven by a small behavioural mac that accumulates the streamed products.
module tb_mac_operand_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, wr_sel, go;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_data;

   logic        busy1, start1, rv1, terr1, done1;
   logic [7:0]  dina1, dinb1;
   logic [15:0] res1, dout1;
   logic        busy4, start4, rv4, terr4, done4;
   logic [31:0] dina4, dinb4;
   logic [15:0] res4, dout4;

   int          mode;   // 0 done low, 1 normal mac, 2 never done, 3 done forced high
   int          acc1, cnt1, acc4, cnt4;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mac_operand_feeder #(.PARALLEL(1), .DEPTH(25), .DW(8), .AW(5), .TIMEOUT(500)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .busy(busy1), .mac_start(start1), .din_a(dina1), .din_b(dinb1),
      .mac_done(done1), .mac_dout(dout1), .result(res1), .result_valid(rv1), .timeout_err(terr1));

   mac_operand_feeder #(.PARALLEL(4), .DEPTH(25), .DW(8), .AW(5), .TIMEOUT(500)) dut4 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .busy(busy4), .mac_start(start4), .din_a(dina4), .din_b(dinb4),
      .mac_done(done4), .mac_dout(dout4), .result(res4), .result_valid(rv4), .timeout_err(terr4));

   always @(negedge clk) begin
      if (rst || mode == 0) begin
         done1 = 1'b0; acc1 = 0; cnt1 = 0;
      end else if (mode == 3) begin
         done1 = 1'b1; dout1 = 16'hBEEF;
      end else if (!start1) begin
         done1 = 1'b0; acc1 = 0; cnt1 = 0;
      end else if (cnt1 < 25) begin
         acc1 += int'(dina1) * int'(dinb1);
         cnt1++;
         if (cnt1 == 25 && mode == 1) begin done1 = 1'b1; dout1 = acc1[15:0]; end
      end
   end

   always @(negedge clk) begin
      if (rst || mode == 0) begin
         done4 = 1'b0; acc4 = 0; cnt4 = 0;
      end else if (mode == 3) begin
         done4 = 1'b1; dout4 = 16'hBEEF;
      end else if (!start4) begin
         done4 = 1'b0; acc4 = 0; cnt4 = 0;
      end else if (cnt4 < 7) begin
         for (int j = 0; j < 4; j++) acc4 += int'(dina4[j*8 +: 8]) * int'(dinb4[j*8 +: 8]);
         cnt4++;
         if (cnt4 == 7 && mode == 1) begin done4 = 1'b1; dout4 = acc4[15:0]; end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic write_op(input logic sel, input int addr, input logic [7:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_go;
      @(negedge clk); go = 1'b1;
      @(posedge clk); #1; go = 1'b0;
   endtask

   // Steps until both feeders are idle, collecting result_valid pulses and captured results.
   task automatic run_wait(output int v1, output int v4, output logic [15:0] r1, output logic [15:0] r4);
      bit idle = 0;
      v1 = 0; v4 = 0; r1 = 'x; r4 = 'x;
      for (int c = 0; c < 700; c++) begin
         if (rv1) begin v1++; r1 = res1; end
         if (rv4) begin v4++; r4 = res4; end
         if (!busy1 && !busy4) begin idle = 1; break; end
         tick();
      end
      checks++;
      if (!idle) begin failures++; $display("FAIL run_wait_bound busy1=%b busy4=%b required idle", busy1, busy4); end
   endtask

   task automatic test_reset;
      rst = 1'b1; go = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; mode = 0;
      #1;
      checks++; if ({busy1, start1, rv1, terr1} !== 4'b0) begin failures++; $display("FAIL reset_flags1 got=%b exp=0000", {busy1, start1, rv1, terr1}); end
      checks++; if ({dina1, dinb1, res1} !== 32'h0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", {dina1, dinb1, res1}); end
      checks++; if ({busy4, start4, rv4, terr4, dina4, dinb4, res4} !== '0) begin failures++; $display("FAIL reset_all4 got=%h exp=0", {busy4, start4, rv4, terr4, dina4, dinb4, res4}); end
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 25; i++) write_op(1'b0, i, 8'(i + 1));
      for (int i = 0; i < 25; i++) write_op(1'b1, i, 8'h01);
   endtask

   task automatic test_stream_p1;
      mode = 1;
      pulse_go();
      for (int k = 0; k < 25; k++) begin
         checks++; if (dina1 !== 8'(k + 1)) begin failures++; $display("FAIL p1_din_a beat=%0d got=%h exp=%h", k, dina1, 8'(k + 1)); end
         checks++; if ({start1, busy1, rv1, dinb1} !== {3'b110, 8'h01}) begin failures++; $display("FAIL p1_ctrl beat=%0d got=%b/%b/%b/%h exp=1/1/0/01", k, start1, busy1, rv1, dinb1); end
         tick();
      end
      checks++; if (dina1 !== 8'h00) begin failures++; $display("FAIL p1_din_after got=%h exp=00", dina1); end
      checks++; if (rv1 !== 1'b1 || res1 !== 16'h0145) begin failures++; $display("FAIL p1_capture rv=%b res=%h exp rv=1 res=0145", rv1, res1); end
      checks++; if (start1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL p1_done_state start=%b busy=%b exp 0/1", start1, busy1); end
      tick();
      checks++; if (rv1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL p1_return rv=%b busy=%b exp 0/0", rv1, busy1); end
   endtask

   task automatic test_parallel4;
      logic [31:0] exp;
      int v1, v4;
      logic [15:0] r1, r4;
      mode = 1;
      pulse_go();
      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < 4; j++) exp[j*8 +: 8] = (k * 4 + j < 25) ? 8'(k * 4 + j + 1) : 8'h00;
         checks++; if (dina4 !== exp) begin failures++; $display("FAIL p4_din_a beat=%0d got=%h exp=%h", k, dina4, exp); end
         if (k == 6) begin
            checks++; if (dina4 !== 32'h0000_0019 || dinb4 !== 32'h0000_0001) begin failures++; $display("FAIL p4_last_beat got=%h/%h exp=00000019/00000001", dina4, dinb4); end
         end
         tick();
      end
      checks++; if (rv4 !== 1'b1 || res4 !== 16'h0145 || dina4 !== 32'h0) begin failures++; $display("FAIL p4_capture rv=%b res=%h din=%h exp 1/0145/0", rv4, res4, dina4); end
      run_wait(v1, v4, r1, r4);
      checks++; if (r1 !== 16'h0145 || v1 !== 1) begin failures++; $display("FAIL p4_run_p1 res=%h pulses=%0d exp 0145/1", r1, v1); end
   endtask

   task automatic test_timeout;
      int v1, v4;
      logic [15:0] r1, r4;
      mode = 2;
      pulse_go();
      repeat (25) tick();
      checks++; if (busy1 !== 1'b1 || start1 !== 1'b1 || dina1 !== 8'h00 || terr1 !== 1'b0) begin failures++; $display("FAIL to_wait_entry busy=%b start=%b din=%h err=%b exp 1/1/00/0", busy1, start1, dina1, terr1); end
      repeat (499) tick();
      checks++; if (terr1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL to_early err=%b busy=%b exp 0/1", terr1, busy1); end
      tick();
      checks++; if (terr1 !== 1'b1 || busy1 !== 1'b0 || start1 !== 1'b0) begin failures++; $display("FAIL to_fire err=%b busy=%b start=%b exp 1/0/0", terr1, busy1, start1); end
      checks++; if (res1 !== 16'h0145 || terr4 !== 1'b1) begin failures++; $display("FAIL to_hold res=%h err4=%b exp 0145/1", res1, terr4); end
      tick();
      checks++; if (terr1 !== 1'b1) begin failures++; $display("FAIL to_sticky err=%b exp 1", terr1); end
      mode = 1;
      pulse_go();
      checks++; if (terr1 !== 1'b0 || terr4 !== 1'b0) begin failures++; $display("FAIL to_clear err1=%b err4=%b exp 0/0", terr1, terr4); end
      run_wait(v1, v4, r1, r4);
      checks++; if (r1 !== 16'h0145 || r4 !== 16'h0145) begin failures++; $display("FAIL to_rerun res1=%h res4=%h exp 0145/0145", r1, r4); end
   endtask

   task automatic test_reset_mid;
      int v1, v4;
      logic [15:0] r1, r4;
      mode = 1;
      pulse_go();
      repeat (10) tick();
      checks++; if (dina1 !== 8'h0B) begin failures++; $display("FAIL rm_beat10 got=%h exp=0B", dina1); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({busy1, start1, rv1, terr1, dina1, dinb1, res1} !== '0) begin failures++; $display("FAIL rm_async got=%h exp=0", {busy1, start1, rv1, terr1, dina1, dinb1, res1}); end
      @(negedge clk); rst = 1'b0;
      pulse_go();
      checks++; if (dina1 !== 8'h01 || busy1 !== 1'b1) begin failures++; $display("FAIL rm_restart din=%h busy=%b exp 01/1", dina1, busy1); end
      run_wait(v1, v4, r1, r4);
      checks++; if (r1 !== 16'h0145 || v1 !== 1 || r4 !== 16'h0145) begin failures++; $display("FAIL rm_result res1=%h pulses=%0d res4=%h exp 0145/1/0145", r1, v1, r4); end
   endtask

   task automatic test_busy_ignore;
      int v1, v4;
      logic [15:0] r1, r4;
      mode = 1;
      pulse_go();
      repeat (3) tick();
      @(negedge clk);
      go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'hFF;
      @(posedge clk); #1;
      go = 1'b0; wr_en = 1'b0;
      run_wait(v1, v4, r1, r4);
      checks++; if (r1 !== 16'h0145 || v1 !== 1 || r4 !== 16'h0145) begin failures++; $display("FAIL bi_result res1=%h pulses=%0d res4=%h exp 0145/1/0145", r1, v1, r4); end
      tick();
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL bi_no_restart busy=%b exp 0", busy1); end
      write_op(1'b0, 0, 8'hFF);
      pulse_go();
      run_wait(v1, v4, r1, r4);
      checks++; if (r1 !== 16'h0243 || r4 !== 16'h0243) begin failures++; $display("FAIL bi_new_data res1=%h res4=%h exp 0243/0243", r1, r4); end
   endtask

   task automatic test_done_held;
      int v1, v4;
      logic [15:0] r1, r4;
      int early;
      mode = 3;
      repeat (3) tick();
      pulse_go();
      early = 0;
      for (int k = 0; k < 10; k++) begin
         if (rv1 || rv4 || !busy1) early++;
         tick();
      end
      checks++; if (early !== 0) begin failures++; $display("FAIL dh_no_capture hits=%0d exp 0", early); end
      mode = 0;
      repeat (2) tick();
      mode = 3;
      run_wait(v1, v4, r1, r4);
      checks++; if (v1 !== 1 || r1 !== 16'hBEEF) begin failures++; $display("FAIL dh_capture1 pulses=%0d res=%h exp 1/BEEF", v1, r1); end
      checks++; if (v4 !== 1 || r4 !== 16'hBEEF) begin failures++; $display("FAIL dh_capture4 pulses=%0d res=%h exp 1/BEEF", v4, r4); end
      mode = 0;
   endtask

   initial begin
      test_reset();
      test_stream_p1();
      repeat (2) tick();
      test_parallel4();
      test_timeout();
      test_reset_mid();
      test_busy_ignore();
      test_done_held();
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Upstream stage of the mac datapath. Holds two DEPTH-entry operand vectors (A and B) loaded through a simple write port, then on a go command streams them PARALLEL lanes per clock onto mac din_a/din_b, holding mac start high for the whole run. It zero-pads lanes past the vector end, captures mac dout when mac done rises, and flags a timeout if done never arrives.

Parameters:
PARALLEL, 1, number of 8-bit lanes per beat; legal range 1..DEPTH.
DEPTH, 25, entries per operand vector.
DW, 8, operand width per lane.
AW, 5, write address width; 2^AW >= DEPTH.
TIMEOUT, 500, max cycles in WAIT before error.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
wr_en  in  1  operand write strobe.
wr_sel  in  1  0 = vector A, 1 = vector B.
wr_addr  in  AW  entry index.
wr_data  in  DW  entry value.
go  in  1  start-run request, sampled in IDLE only.
busy  out  1  high from the edge after go until return to IDLE.
mac_start  out  1  drives mac start.
din_a  out  PARALLEL*DW  lane j at bits [(j+1)*DW-1 : j*DW].
din_b  out  PARALLEL*DW  same packing as din_a.
mac_done  in  1  mac done.
mac_dout  in  16  mac result.
result  out  16  captured mac_dout.
result_valid  out  1  one-cycle pulse on capture.
timeout_err  out  1  sticky error; cleared by the next accepted go or by rst.

Behaviour:
- Reset (async, any state): state=IDLE; busy, mac_start, result_valid, timeout_err = 0; din_a, din_b, result = 0; beat index = 0. Operand memories are not reset.
- Writes: accepted only when busy=0. Addresses >= DEPTH are ignored. Writes while busy=1 are dropped.
- N = ceil(DEPTH/PARALLEL) beats. Beat k, lane j carries A[k*PARALLEL+j] and B[k*PARALLEL+j]. Any lane with index >= DEPTH carries 0.
- FSM states: IDLE, STREAM, WAIT, DONE.
- IDLE: when go=1 at edge E0, go to STREAM. From E0: busy=1, mac_start=1, din=beat 0, timeout_err=0.
- STREAM: at edges E1..E(N-1), din=beat 1..beat N-1 (one beat per cycle, no stalls). At edge EN, din=0 and state goes to WAIT. If N=1, E1 goes directly to WAIT.
- mac_done rising edge is detected with a registered previous value (prev=0, now=1). Detection in STREAM or WAIT: result<=mac_dout, result_valid=1 for one cycle, mac_start<=0, state goes to DONE.
  - In STREAM this ends streaming early.
  - If the rise and the final beat occur on the same edge, the capture wins.
- WAIT: cycle counter starts at 0 on entry. If it reaches TIMEOUT-1 with no done rise: timeout_err=1, mac_start=0, din=0, result unchanged, state goes to IDLE.
- DONE: one cycle. busy drops to 0 on the exit edge; state goes to IDLE.
- go while busy=1 is ignored. mac_done while IDLE is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. PARALLEL=1; load A[i]=i+1, B[i]=1; pulse go; the bench model MAC accumulates the din_a*din_b products it receives and drives done after 25 beats -> din_a sequence is 0x01..0x19 on consecutive cycles, then 0x00; result=16'h0145; result_valid pulses exactly once; busy returns to 0.
2. PARALLEL=4, same data -> 7 beats; beat 6 has din_a = {8'h00, 8'h00, 8'h00, 8'h19}; lane sum 325 -> result=16'h0145.
3. Bench MAC never raises done -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT; state=IDLE; the next go clears timeout_err.
4. Assert rst at beat 10 of stream -> outputs are 0 immediately (async); memory retained; a new go streams the full vector from beat 0 and gives result 16'h0145.
5. During STREAM, pulse go and write A[0]=0xFF -> run unaffected and result=16'h0145; a second run after IDLE uses A[0]=0xFF -> result=16'h0243.
6. mac_done held high from before go -> no capture until a fresh rising edge; verify result_valid pulses only on a 0-to-1 transition.
